// File: rtl/real_window_stats.sv
// Non-overlapping window statistics (sum, floor mean, min, max) over 2**LOG2_N
// accepted samples of a signed fixed-point real stream; exponent passes through.
module real_window_stats #(
    parameter int IN_WIDTH    = 25,
    parameter int IN_EXPONENT = -16,
    parameter int LOG2_N      = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic signed [IN_WIDTH-1:0]          in_data,
    input  logic                                in_valid,
    input  logic                                clear,
    output logic signed [IN_WIDTH+LOG2_N-1:0]   out_sum,
    output logic signed [IN_WIDTH-1:0]          out_mean,
    output logic signed [IN_WIDTH-1:0]          out_min,
    output logic signed [IN_WIDTH-1:0]          out_max,
    output logic                                out_valid,
    output logic        [LOG2_N-1:0]            fill,
    output logic        [CNT_WIDTH-1:0]         windows_done
);

    localparam int SUM_WIDTH = IN_WIDTH + LOG2_N;
    localparam logic [LOG2_N-1:0]    FILL_ONE = LOG2_N'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    if (LOG2_N < 1 || LOG2_N > 8 || IN_EXPONENT < -1024 || IN_EXPONENT > 1023) begin : g_param_check
        $error("real_window_stats: LOG2_N or IN_EXPONENT out of range");
    end

    logic        [LOG2_N-1:0]    fill_reg;
    logic signed [SUM_WIDTH-1:0] acc_sum_reg;
    logic signed [IN_WIDTH-1:0]  acc_min_reg;
    logic signed [IN_WIDTH-1:0]  acc_max_reg;
    logic signed [SUM_WIDTH-1:0] out_sum_reg;
    logic signed [IN_WIDTH-1:0]  out_mean_reg;
    logic signed [IN_WIDTH-1:0]  out_min_reg;
    logic signed [IN_WIDTH-1:0]  out_max_reg;
    logic                        out_valid_reg;
    logic        [CNT_WIDTH-1:0] windows_done_reg;

    logic                        seed;
    logic                        complete;
    logic signed [SUM_WIDTH-1:0] in_ext;
    logic signed [SUM_WIDTH-1:0] sum_next;
    logic signed [IN_WIDTH-1:0]  min_next;
    logic signed [IN_WIDTH-1:0]  max_next;

    // The first sample of a window (including one arriving with clear) seeds min/max.
    assign seed     = (fill_reg == '0) || clear;
    assign complete = (fill_reg == '1) && !clear;
    assign in_ext   = {{LOG2_N{in_data[IN_WIDTH-1]}}, in_data};

    always_comb begin
        sum_next = acc_sum_reg + in_ext;
        min_next = (in_data < acc_min_reg) ? in_data : acc_min_reg;
        max_next = (in_data > acc_max_reg) ? in_data : acc_max_reg;
        if (seed) begin
            sum_next = in_ext;
            min_next = in_data;
            max_next = in_data;
        end
    end

    always_ff @(posedge clk) begin
        out_valid_reg <= 1'b0;
        if (rst) begin
            fill_reg         <= '0;
            acc_sum_reg      <= '0;
            acc_min_reg      <= '0;
            acc_max_reg      <= '0;
            out_sum_reg      <= '0;
            out_mean_reg     <= '0;
            out_min_reg      <= '0;
            out_max_reg      <= '0;
            windows_done_reg <= '0;
        end else if (in_valid) begin
            acc_sum_reg <= sum_next;
            acc_min_reg <= min_next;
            acc_max_reg <= max_next;
            fill_reg    <= clear ? FILL_ONE : fill_reg + FILL_ONE;
            if (complete) begin
                out_sum_reg   <= sum_next;
                // Upper bits of the sum are exactly the arithmetic shift right by LOG2_N.
                out_mean_reg  <= sum_next[SUM_WIDTH-1:LOG2_N];
                out_min_reg   <= min_next;
                out_max_reg   <= max_next;
                out_valid_reg <= 1'b1;
                if (windows_done_reg != '1)
                    windows_done_reg <= windows_done_reg + CNT_ONE;
            end
        end else if (clear) begin
            fill_reg <= '0;
        end
    end

    assign out_sum      = out_sum_reg;
    assign out_mean     = out_mean_reg;
    assign out_min      = out_min_reg;
    assign out_max      = out_max_reg;
    assign out_valid    = out_valid_reg;
    assign fill         = fill_reg;
    assign windows_done = windows_done_reg;

endmodule

// File: tb/tb_real_window_stats.sv
// Scoreboard bench for real_window_stats: stimulus pushes expected windows,
// a negedge monitor pops and compares on every out_valid pulse.
module tb_real_window_stats;

    localparam int IW = 25;
    localparam int LN = 2;
    localparam int CW = 16;

    typedef struct {
        longint sum;
        longint mean;
        longint min;
        longint max;
        longint wd;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic signed [IW-1:0]     in_data = '0;
    logic                     in_valid = 1'b0;
    logic                     clear = 1'b0;
    logic signed [IW+LN-1:0]  out_sum;
    logic signed [IW-1:0]     out_mean;
    logic signed [IW-1:0]     out_min;
    logic signed [IW-1:0]     out_max;
    logic                     out_valid;
    logic        [LN-1:0]     fill;
    logic        [CW-1:0]     windows_done;

    exp_t   sb[$];
    int     pass_cnt = 0;
    int     total_cnt = 0;
    longint exp_wd = 0;

    real_window_stats #(.IN_WIDTH(IW), .IN_EXPONENT(-16), .LOG2_N(LN), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .clear(clear),
        .out_sum(out_sum), .out_mean(out_mean), .out_min(out_min), .out_max(out_max),
        .out_valid(out_valid), .fill(fill), .windows_done(windows_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint req);
        total_cnt++;
        if (act == req) begin
            pass_cnt++;
            $display("check %-12s got %0d ok", name, act);
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic expect_window(input longint s, input longint m, input longint mn, input longint mx);
        exp_t e;
        exp_wd++;
        e.sum = s; e.mean = m; e.min = mn; e.max = mx; e.wd = exp_wd;
        sb.push_back(e);
    endtask

    task automatic send(input longint d, input logic clr);
        in_data  = IW'(d);
        in_valid = 1'b1;
        clear    = clr;
        @(posedge clk); #1;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Monitor: every out_valid pulse must match the oldest expected window.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexp_pulse", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("out_sum", longint'(out_sum), e.sum);
                    chk("out_mean", longint'(out_mean), e.mean);
                    chk("out_min", longint'(out_min), e.min);
                    chk("out_max", longint'(out_max), e.max);
                    chk("windows_done", longint'(windows_done), e.wd);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle(2);
        rst = 1'b0;
        chk("rst_sum", longint'(out_sum), 0);
        chk("rst_mean", longint'(out_mean), 0);
        chk("rst_min", longint'(out_min), 0);
        chk("rst_max", longint'(out_max), 0);
        chk("rst_valid", longint'(out_valid), 0);
        chk("rst_fill", longint'(fill), 0);
        chk("rst_wd", longint'(windows_done), 0);

        // Constant 10.0 for 8 back-to-back cycles: two windows.
        expect_window(2621440, 655360, 655360, 655360);
        expect_window(2621440, 655360, 655360, 655360);
        for (int i = 0; i < 8; i++) send(655360, 1'b0);
        idle(2);
        chk("wd_after_8", longint'(windows_done), 2);

        // 1.0, 2.0, -3.0, 4.0 with gaps.
        expect_window(262144, 65536, -196608, 262144);
        send(65536, 1'b0);   idle(1);
        send(131072, 1'b0);  idle(1);
        send(-196608, 1'b0); idle(1);
        send(262144, 1'b0);  idle(2);

        // Floor toward -inf, then a positive truncation.
        expect_window(-1, -1, -1, 0);
        send(-1, 1'b0); for (int i = 0; i < 3; i++) send(0, 1'b0);
        expect_window(3, 0, 0, 3);
        send(3, 1'b0); for (int i = 0; i < 3; i++) send(0, 1'b0);
        idle(2);

        // Extremes of the input range.
        expect_window(67108860, 16777215, 16777215, 16777215);
        for (int i = 0; i < 4; i++) send(16777215, 1'b0);
        expect_window(-67108864, -16777216, -16777216, -16777216);
        for (int i = 0; i < 4; i++) send(-16777216, 1'b0);
        idle(2);

        // Clear alone after 3 samples of 5.0 discards them without a pulse.
        for (int i = 0; i < 3; i++) send(327680, 1'b0);
        chk("fill_before_clr", longint'(fill), 3);
        clear = 1'b1; idle(1); clear = 1'b0;
        chk("fill_after_clr", longint'(fill), 0);
        expect_window(262144, 65536, 65536, 65536);
        for (int i = 0; i < 4; i++) send(65536, 1'b0);
        idle(2);

        // Clear with a sample at fill == N-1: no completion, sample seeds a new window.
        for (int i = 0; i < 3; i++) send(65536, 1'b0);
        send(458752, 1'b1);
        chk("fill_clr_smp", longint'(fill), 1);
        expect_window(1835008, 458752, 458752, 458752);
        for (int i = 0; i < 3; i++) send(458752, 1'b0);
        idle(2);

        // rst mid-window clears everything; counting restarts.
        send(131072, 1'b0); send(131072, 1'b0);
        rst = 1'b1; idle(1); rst = 1'b0;
        exp_wd = 0;
        chk("rst2_sum", longint'(out_sum), 0);
        chk("rst2_mean", longint'(out_mean), 0);
        chk("rst2_fill", longint'(fill), 0);
        chk("rst2_wd", longint'(windows_done), 0);
        expect_window(524288, 131072, 131072, 131072);
        for (int i = 0; i < 4; i++) send(131072, 1'b0);
        idle(3);

        chk("sb_empty", longint'(sb.size()), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
